// File: rtl/display_page_sequencer.sv
// rtl/display_page_sequencer.sv - short/long button press page selector with auto-rotate for the 7-segment display (optional: AUTO_SKIP_ZERO_EN)
module display_page_sequencer #(
  parameter int TICK_DIV     = 100000000,
  parameter int LONG_CYCLES  = 50000000,
  parameter int ROTATE_TICKS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn,
  input  logic [15:0] pts,
  input  logic [15:0] hpts,
  input  logic [15:0] times,
  input  logic [15:0] rounds,
  output logic [1:0]  page,
  output logic [15:0] display_number,
  output logic        auto_mode,
  output logic        short_pulse,
  output logic        long_pulse
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam int RW = $clog2(ROTATE_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LONG = HW'(LONG_CYCLES);
  localparam logic [RW-1:0] ROT_LAST  = RW'(ROTATE_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HELD  = 2'd2
  } btn_state_t;

  btn_state_t    state;
  btn_state_t    state_next;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_next;
  logic          short_next;
  logic          long_next;
  // Set once btn has been seen low; keeps a press that straddles reset from counting.
  logic          armed;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [RW-1:0] rot_cnt;
  logic [1:0]    auto_target;
  logic [15:0]   vals [4];

  assign vals[0] = pts;
  assign vals[1] = hpts;
  assign vals[2] = times;
  assign vals[3] = rounds;

  // Button FSM state, hold counter and registered press pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
      armed       <= 1'b0;
    end else begin
      state       <= state_next;
      hold_cnt    <= hold_next;
      short_pulse <= short_next;
      long_pulse  <= long_next;
      armed       <= armed | ~btn;
    end
  end

  // Press classification: release before the hold limit is short, reaching it is long.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    short_next = 1'b0;
    long_next  = 1'b0;
    case (state)
      IDLE: begin
        if (btn && armed) begin
          state_next = COUNT;
          hold_next  = HW'(1);
        end
      end
      COUNT: begin
        if (!btn) begin
          short_next = 1'b1;
          state_next = IDLE;
        end else if (hold_cnt >= HOLD_LONG) begin
          long_next  = 1'b1;
          state_next = HELD;
        end else begin
          hold_next = hold_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!btn) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign tick = (tick_cnt == TICK_LAST);

  // Free-running divider producing the one-cycle rotation tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Destination page for an auto-rotate step.
  always_comb begin
`ifdef AUTO_SKIP_ZERO_EN
    // Nearest following page with a nonzero value; stay put if there is none.
    auto_target = page;
    for (int k = 3; k >= 1; k--) begin
      if (vals[page + 2'(k)] != 16'd0) begin
        auto_target = page + 2'(k);
      end
    end
`else
    auto_target = page + 2'd1;
`endif
  end

  // Page and auto-mode control; a press always takes priority over the tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      page      <= 2'd0;
      auto_mode <= 1'b0;
      rot_cnt   <= '0;
    end else if (short_pulse) begin
      page    <= page + 2'd1;
      rot_cnt <= '0;
    end else if (long_pulse) begin
      auto_mode <= ~auto_mode;
      rot_cnt   <= '0;
    end else if (!auto_mode) begin
      rot_cnt <= '0;
    end else if (tick) begin
      if (rot_cnt == ROT_LAST) begin
        page    <= auto_target;
        rot_cnt <= '0;
      end else begin
        rot_cnt <= rot_cnt + 1'b1;
      end
    end
  end

  // Display value follows the registered page one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      display_number <= 16'd0;
    end else begin
      display_number <= vals[page];
    end
  end

endmodule

// File: tb/tb_display_page_sequencer.sv
// tb/tb_display_page_sequencer.sv - scoreboard bench for display_page_sequencer
module tb_display_page_sequencer;

  localparam int TD = 10;
  localparam int LC = 20;
  localparam int RT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn = 1'b0;
  logic [15:0] pts = 16'd1;
  logic [15:0] hpts = 16'd2;
  logic [15:0] times = 16'd3;
  logic [15:0] rounds = 16'd4;
  logic [1:0]  page;
  logic [15:0] display_number;
  logic        auto_mode;
  logic        short_pulse;
  logic        long_pulse;

  display_page_sequencer #(
    .TICK_DIV    (TD),
    .LONG_CYCLES (LC),
    .ROTATE_TICKS(RT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn           (btn),
    .pts           (pts),
    .hpts          (hpts),
    .times         (times),
    .rounds        (rounds),
    .page          (page),
    .display_number(display_number),
    .auto_mode     (auto_mode),
    .short_pulse   (short_pulse),
    .long_pulse    (long_pulse)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_short = 0;
  int n_long = 0;
  int long_cyc = 0;
  int chg_cnt = 0;
  int last_chg = 0;
  logic [1:0] exp_q [$];
  logic [1:0] prev_page = 2'd0;

  function automatic logic [15:0] sel(input logic [1:0] p);
    case (p)
      2'd0: sel = pts;
      2'd1: sel = hpts;
      2'd2: sel = times;
      default: sel = rounds;
    endcase
  endfunction

  // One clock: observe at the falling edge, score page changes and display latency.
  task automatic step();
    logic [15:0] want;
    logic [1:0]  e_pg;
    bit          wv;
    want = sel(page);
    wv   = !rst;
    @(negedge clk);
    cyc++;
    if (!rst) begin
      if (short_pulse) n_short++;
      if (long_pulse) begin
        n_long++;
        long_cyc = cyc;
      end
      if (page !== prev_page) begin
        chg_cnt++;
        last_chg = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL page_unexpected: page=%0d (was %0d), no change expected at cyc %0d", page, prev_page, cyc);
        end else begin
          e_pg = exp_q.pop_front();
          if (page !== e_pg) begin
            errors++;
            $display("FAIL page_seq: got %0d want %0d at cyc %0d", page, e_pg, cyc);
          end
        end
      end
      if (wv) begin
        checks++;
        if (display_number !== want) begin
          errors++;
          $display("FAIL display_number: got %0d want %0d at cyc %0d", display_number, want, cyc);
        end
      end
    end
    prev_page = page;
  endtask

  task automatic wait_change(input int limit);
    int c0;
    int n;
    c0 = chg_cnt;
    n  = 0;
    while (chg_cnt == c0 && n < limit) begin
      step();
      n++;
    end
    checks++;
    if (chg_cnt == c0) begin
      errors++;
      $display("FAIL wait_change_timeout: no page change within %0d cycles", limit);
    end
  endtask

  task automatic press(input int hold, input int idle);
    btn = 1'b1;
    repeat (hold) step();
    btn = 1'b0;
    repeat (idle) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({page, display_number, auto_mode, short_pulse, long_pulse} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: page=%0d disp=%0d auto=%0b sp=%0b lp=%0b want all 0",
               page, display_number, auto_mode, short_pulse, long_pulse);
    end
    rst = 1'b0;
    repeat (50) step();
    checks++;
    if (page !== 2'd0 || display_number !== 16'd1 || auto_mode !== 1'b0) begin
      errors++;
      $display("FAIL idle_state: page=%0d disp=%0d auto=%0b want 0/1/0", page, display_number, auto_mode);
    end
    checks++;
    if (n_short != 0 || n_long != 0) begin
      errors++;
      $display("FAIL idle_pulses: short=%0d long=%0d want 0/0", n_short, n_long);
    end
    for (int i = 0; i < 6; i++) begin
      pts = 16'($urandom_range(1, 65535));
      step();
    end
    pts = 16'd1;
    step();
  endtask

  task automatic test_short_press();
    int s0;
    int l0;
    s0 = n_short;
    l0 = n_long;
    exp_q.push_back(2'd1);
    press(5, 5);
    checks++;
    if (n_short - s0 != 1 || n_long - l0 != 0) begin
      errors++;
      $display("FAIL short_pulses: short=%0d long=%0d want 1/0", n_short - s0, n_long - l0);
    end
    checks++;
    if (page !== 2'd1 || display_number !== 16'd2) begin
      errors++;
      $display("FAIL short_page: page=%0d disp=%0d want 1/2", page, display_number);
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(2'(i + 2));
      press(3 + i, 4);
    end
    checks++;
    if (page !== 2'd0 || n_short - s0 != 4) begin
      errors++;
      $display("FAIL short_wrap: page=%0d shorts=%0d want 0/4", page, n_short - s0);
    end
  endtask

  task automatic test_long_press();
    int s0;
    int l0;
    int c0;
    s0 = n_short;
    l0 = n_long;
    c0 = cyc;
    press(25, 2);
    checks++;
    if (n_long - l0 != 1 || n_short - s0 != 0) begin
      errors++;
      $display("FAIL long_pulses: long=%0d short=%0d want 1/0", n_long - l0, n_short - s0);
    end
    checks++;
    if (long_cyc - c0 != LC + 1) begin
      errors++;
      $display("FAIL long_latency: got %0d want %0d cycles", long_cyc - c0, LC + 1);
    end
    checks++;
    if (auto_mode !== 1'b1 || page !== 2'd0) begin
      errors++;
      $display("FAIL long_toggle: auto=%0b page=%0d want 1/0", auto_mode, page);
    end
  endtask

  task automatic test_auto_rotate();
    int prev;
    int l0;
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    wait_change(40);
    prev = last_chg;
    for (int i = 0; i < 3; i++) begin
      wait_change(40);
      checks++;
      if (last_chg - prev != TD * RT) begin
        errors++;
        $display("FAIL auto_interval: got %0d want %0d cycles", last_chg - prev, TD * RT);
      end
      prev = last_chg;
    end
    l0 = n_long;
    press(25, 60);
    checks++;
    if (auto_mode !== 1'b0 || page !== 2'd0 || n_long - l0 != 1) begin
      errors++;
      $display("FAIL auto_off: auto=%0b page=%0d longs=%0d want 0/0/1", auto_mode, page, n_long - l0);
    end
  endtask

  task automatic test_pulse_tick_collision();
    int m;
    press(25, 2);
    exp_q.push_back(2'd1);
    wait_change(40);
    m = last_chg;
    repeat (23) step();
    btn = 1'b1;
    repeat (5) step();
    btn = 1'b0;
    exp_q.push_back(2'd2);
    wait_change(10);
    checks++;
    if (last_chg - m != TD * RT || page !== 2'd2) begin
      errors++;
      $display("FAIL collide_step: dt=%0d page=%0d want %0d/2", last_chg - m, page, TD * RT);
    end
    exp_q.push_back(2'd3);
    wait_change(40);
    checks++;
    if (last_chg - m != 2 * TD * RT) begin
      errors++;
      $display("FAIL collide_next: dt=%0d want %0d", last_chg - m, 2 * TD * RT);
    end
  endtask

  task automatic test_reset_mid_press();
    int s0;
    int l0;
    btn = 1'b1;
    repeat (15) step();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({page, display_number, auto_mode, short_pulse, long_pulse} !== 21'd0) begin
      errors++;
      $display("FAIL midreset_outputs: page=%0d disp=%0d auto=%0b want all 0", page, display_number, auto_mode);
    end
    rst = 1'b0;
    s0 = n_short;
    l0 = n_long;
    repeat (40) step();
    checks++;
    if (n_short - s0 != 0 || n_long - l0 != 0 || page !== 2'd0 || auto_mode !== 1'b0) begin
      errors++;
      $display("FAIL midreset_hold: short=%0d long=%0d page=%0d auto=%0b want 0/0/0/0",
               n_short - s0, n_long - l0, page, auto_mode);
    end
    btn = 1'b0;
    repeat (3) step();
    exp_q.push_back(2'd1);
    press(5, 5);
    checks++;
    if (n_short - s0 != 1 || page !== 2'd1) begin
      errors++;
      $display("FAIL midreset_rearm: short=%0d page=%0d want 1/1", n_short - s0, page);
    end
  endtask

`ifdef AUTO_SKIP_ZERO_EN
  task automatic test_skip_zero();
    hpts  = 16'd0;
    times = 16'd0;
    press(25, 2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd3);
    for (int i = 0; i < 3; i++) wait_change(40);
    checks++;
    if (page !== 2'd3) begin
      errors++;
      $display("FAIL skip_zero: page=%0d want 3", page);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_short_press();
    test_long_press();
    test_auto_rotate();
    test_pulse_tick_collision();
    test_reset_mid_press();
`ifdef AUTO_SKIP_ZERO_EN
    test_skip_zero();
`endif
    repeat (2) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected page changes never seen", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
